// File: rtl/pcie_phy_8b10b_enc_multi.sv
// -----------------------------------------------------------------------------
// pcie_phy_8b10b_enc_multi
//   Multi-symbol 8b/10b encoder for the PCIe PHY TX datapath. Encodes BYTES
//   characters per clock (symbol 0 first on the wire) and chains running
//   disparity from symbol to symbol and from word to word. Codes are built
//   from 5b/6b and 3b/4b sub-block logic, so latency is a fixed one clock.
//
// Ports
//   clk          TX symbol clock
//   rst_n        asynchronous active-low reset
//   in_valid     input word valid
//   in_data      BYTES characters, byte i = [8i+7:8i], HGFEDCBA (A = LSB)
//   in_k         per-byte control flag (1 = K character)
//   in_elec_idle force all-zero output word, running disparity frozen
//   rd_load      preload running disparity before encoding this word
//   rd_load_val  preload value (0 = RD-, 1 = RD+)
//   out_valid    output word valid
//   out_data     BYTES symbols, symbol i = [10i+9:10i] = {j,h,g,f,i,e,d,c,b,a}
//   out_rd       running disparity after the last symbol of the output word
//   err_k        per-symbol flag: K requested for a byte that is not a K code
// -----------------------------------------------------------------------------
module pcie_phy_8b10b_enc_multi #(
    parameter int BYTES   = 2,
    parameter bit CHECK_K = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [8*BYTES-1:0]   in_data,
    input  logic [BYTES-1:0]     in_k,
    input  logic                 in_elec_idle,
    input  logic                 rd_load,
    input  logic                 rd_load_val,
    output logic                 out_valid,
    output logic [10*BYTES-1:0]  out_data,
    output logic                 out_rd,
    output logic [BYTES-1:0]     err_k
);

    // Twelve legal control characters: K28.0-7 plus K23/27/29/30.7.
    function automatic logic is_k_code(input logic [7:0] b);
        return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) ||
               (b == 8'hFD) || (b == 8'hFE);
    endfunction

    // 5b/6b data codes for RD-, written abcdei; MSB flags an unbalanced code.
    function automatic logic [6:0] d6_neg(input logic [4:0] x);
        case (x)
            5'd0:  d6_neg = 7'b1_100111;
            5'd1:  d6_neg = 7'b1_011101;
            5'd2:  d6_neg = 7'b1_101101;
            5'd3:  d6_neg = 7'b0_110001;
            5'd4:  d6_neg = 7'b1_110101;
            5'd5:  d6_neg = 7'b0_101001;
            5'd6:  d6_neg = 7'b0_011001;
            5'd7:  d6_neg = 7'b0_111000;
            5'd8:  d6_neg = 7'b1_111001;
            5'd9:  d6_neg = 7'b0_100101;
            5'd10: d6_neg = 7'b0_010101;
            5'd11: d6_neg = 7'b0_110100;
            5'd12: d6_neg = 7'b0_001101;
            5'd13: d6_neg = 7'b0_101100;
            5'd14: d6_neg = 7'b0_011100;
            5'd15: d6_neg = 7'b1_010111;
            5'd16: d6_neg = 7'b1_011011;
            5'd17: d6_neg = 7'b0_100011;
            5'd18: d6_neg = 7'b0_010011;
            5'd19: d6_neg = 7'b0_110010;
            5'd20: d6_neg = 7'b0_001011;
            5'd21: d6_neg = 7'b0_101010;
            5'd22: d6_neg = 7'b0_011010;
            5'd23: d6_neg = 7'b1_111010;
            5'd24: d6_neg = 7'b1_110011;
            5'd25: d6_neg = 7'b0_100110;
            5'd26: d6_neg = 7'b0_010110;
            5'd27: d6_neg = 7'b1_110110;
            5'd28: d6_neg = 7'b0_001110;
            5'd29: d6_neg = 7'b1_101110;
            5'd30: d6_neg = 7'b1_011110;
            default: d6_neg = 7'b1_101011;
        endcase
    endfunction

    // 3b/4b data codes (fghj) used when the disparity after the 6b block is -.
    function automatic logic [4:0] d4_neg(input logic [2:0] y, input logic alt7);
        case (y)
            3'd0:    d4_neg = 5'b1_1011;
            3'd1:    d4_neg = 5'b0_1001;
            3'd2:    d4_neg = 5'b0_0101;
            3'd3:    d4_neg = 5'b0_1100;
            3'd4:    d4_neg = 5'b1_1101;
            3'd5:    d4_neg = 5'b0_1010;
            3'd6:    d4_neg = 5'b0_0110;
            default: d4_neg = alt7 ? 5'b1_0111 : 5'b1_1110;
        endcase
    endfunction

    // 3b/4b control codes when the disparity after the 6b block is -.
    // Unlike data, the neutral K variants also invert with disparity.
    function automatic logic [4:0] k4_neg(input logic [2:0] y);
        case (y)
            3'd0:    k4_neg = 5'b1_1011;
            3'd1:    k4_neg = 5'b0_0110;
            3'd2:    k4_neg = 5'b0_1010;
            3'd3:    k4_neg = 5'b0_1100;
            3'd4:    k4_neg = 5'b1_1101;
            3'd5:    k4_neg = 5'b0_0101;
            3'd6:    k4_neg = 5'b0_1001;
            default: k4_neg = 5'b1_0111;
        endcase
    endfunction

    // Returns {rd_after_symbol, symbol[9:0]} with a in bit 0.
    function automatic logic [10:0] enc_sym(input logic [7:0] b, input logic is_k,
                                            input logic rd_in);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] s6;
        logic [3:0] s4;
        logic       u6;
        logic       u4;
        logic       rd_mid;
        logic       alt7;
        logic [9:0] full;
        logic [9:0] sym;
        x = b[4:0];
        y = b[7:5];
        {u6, s6} = d6_neg(x);
        if (is_k && (x == 5'd28)) begin
            u6 = 1'b1;
            s6 = 6'b001111;
        end
        // D.7 is neutral but still alternates with disparity.
        if (rd_in && (u6 || (x == 5'd7))) s6 = ~s6;
        rd_mid = rd_in ^ u6;
        if (is_k) begin
            {u4, s4} = k4_neg(y);
            if (rd_mid) s4 = ~s4;
        end else begin
            // Alternate x.7 avoids a run of five equal bits across the sub-blocks.
            alt7 = (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                   ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
            {u4, s4} = d4_neg(y, alt7);
            if (rd_mid && (u4 || (y == 3'd3))) s4 = ~s4;
        end
        full = {s6, s4};
        for (int k = 0; k < 10; k++) sym[k] = full[9-k];
        return {rd_mid ^ u4, sym};
    endfunction

    logic [10*BYTES-1:0] w_sym;
    logic [BYTES-1:0]    w_errk;
    logic                w_rd_end;

    logic                r_vld_p1;
    logic [10*BYTES-1:0] r_data_p1;
    logic [BYTES-1:0]    r_errk_p1;
    logic                r_rd_out_p1;
    logic                r_rd;

    // Stage p0: combinational encode with the disparity chained across symbols.
    always_comb begin
        logic        rd;
        logic [7:0]  b;
        logic        kv;
        logic [10:0] enc;
        w_sym  = '0;
        w_errk = '0;
        rd     = rd_load ? rd_load_val : r_rd;
        for (int i = 0; i < BYTES; i++) begin
            b  = in_data[8*i +: 8];
            kv = in_k[i] && is_k_code(b);
            w_errk[i] = CHECK_K && in_k[i] && !kv;
            enc = enc_sym(b, kv, rd);
            w_sym[10*i +: 10] = enc[9:0];
            rd = enc[10];
        end
        w_rd_end = rd;
    end

    // Stage p1: output registers and running-disparity state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1    <= 1'b0;
            r_data_p1   <= '0;
            r_errk_p1   <= '0;
            r_rd_out_p1 <= 1'b0;
            r_rd        <= 1'b0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                if (in_elec_idle) begin
                    // Idle word carries no disparity; only a preload may move RD.
                    r_data_p1 <= '0;
                    r_errk_p1 <= '0;
                    if (rd_load) r_rd <= rd_load_val;
                end else begin
                    r_data_p1   <= w_sym;
                    r_errk_p1   <= w_errk;
                    r_rd        <= w_rd_end;
                    r_rd_out_p1 <= w_rd_end;
                end
            end
        end
    end

    assign out_valid = r_vld_p1;
    assign out_data  = r_data_p1;
    assign out_rd    = r_rd_out_p1;
    assign err_k     = r_errk_p1;

endmodule

// File: tb/tb_pcie_phy_8b10b_enc_multi.sv
module tb_pcie_phy_8b10b_enc_multi;

    localparam int BYTES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_k;
    logic        in_elec_idle;
    logic        rd_load;
    logic        rd_load_val;
    logic        out_valid;
    logic [19:0] out_data;
    logic        out_rd;
    logic [1:0]  err_k;

    int checks   = 0;
    int failures = 0;

    pcie_phy_8b10b_enc_multi #(.BYTES(BYTES), .CHECK_K(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_k(in_k), .in_elec_idle(in_elec_idle), .rd_load(rd_load),
        .rd_load_val(rd_load_val), .out_valid(out_valid), .out_data(out_data),
        .out_rd(out_rd), .err_k(err_k)
    );

    always #5 clk = ~clk;

    // Reference code tables (standard 8b/10b, RD- column, abcdei / fghj)
    logic [5:0] t6  [32];
    logic [3:0] t4d [8];
    logic [3:0] t4k [8];
    logic [7:0] kset [12];

    // Reference model state
    logic        m_rd, m_vld, m_rdo;
    logic [19:0] m_data;
    logic [1:0]  m_err;

    function automatic bit is_valid_k(input logic [7:0] b);
        for (int n = 0; n < 12; n++) if (kset[n] == b) return 1'b1;
        return 1'b0;
    endfunction

    // Pick the sub-block variant by disparity counting, then lay the bits out
    // by name in transmit order.
    function automatic logic [9:0] m_encode(input logic [7:0] b, input bit k,
                                            input bit rd, output bit rd_o);
        logic [5:0] c6;
        logic [3:0] c4;
        logic [9:0] s;
        int x, y;
        bit rdm;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        c6 = (k && x == 28) ? 6'b001111 : t6[x];
        if (rd && ($countones(c6) != 3 || c6 == 6'b111000)) c6 = ~c6;
        rdm = rd ^ ($countones(c6) != 3);
        if (k) begin
            c4 = t4k[y];
            if (rdm) c4 = ~c4;
        end else begin
            c4 = t4d[y];
            if (y == 7 && ((!rdm && (x == 17 || x == 18 || x == 20)) ||
                           ( rdm && (x == 11 || x == 13 || x == 14)))) c4 = 4'b0111;
            if (rdm && ($countones(c4) != 2 || c4 == 4'b1100)) c4 = ~c4;
        end
        s[0] = c6[5]; s[1] = c6[4]; s[2] = c6[3]; s[3] = c6[2]; s[4] = c6[1];
        s[5] = c6[0]; s[6] = c4[3]; s[7] = c4[2]; s[8] = c4[1]; s[9] = c4[0];
        rd_o = rd ^ ($countones(s) != 5);
        return s;
    endfunction

    task automatic model_reset();
        m_rd = 1'b0; m_vld = 1'b0; m_rdo = 1'b0; m_data = '0; m_err = '0;
    endtask

    task automatic model_clock();
        bit r, rn, kv;
        if (in_valid) begin
            m_vld = 1'b1;
            if (in_elec_idle) begin
                m_data = '0;
                m_err  = '0;
                if (rd_load) m_rd = rd_load_val;
            end else begin
                r = rd_load ? rd_load_val : m_rd;
                for (int i = 0; i < BYTES; i++) begin
                    kv = in_k[i] && is_valid_k(in_data[8*i +: 8]);
                    m_err[i] = in_k[i] && !kv;
                    m_data[10*i +: 10] = m_encode(in_data[8*i +: 8], kv, r, rn);
                    r = rn;
                end
                m_rd  = r;
                m_rdo = r;
            end
        end else begin
            m_vld = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'(m_vld));
        check({tag, "_data"},  32'(out_data),  32'(m_data));
        check({tag, "_rd"},    32'(out_rd),    32'(m_rdo));
        check({tag, "_errk"},  32'(err_k),     32'(m_err));
    endtask

    task automatic check_const(input string tag, input bit v, input logic [19:0] d,
                               input bit rd, input logic [1:0] ek);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_rd"},    32'(out_rd),    32'(rd));
        check({tag, "_errk"},  32'(err_k),     32'(ek));
    endtask

    task automatic drive(input bit v, input logic [1:0] k, input logic [15:0] d,
                         input bit idle, input bit ld, input bit ldv);
        in_valid = v; in_k = k; in_data = d; in_elec_idle = idle;
        rd_load = ld; rd_load_val = ldv;
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    typedef struct {
        bit          v;
        logic [1:0]  k;
        logic [15:0] d;
        bit          idle;
        bit          ld;
        bit          ldv;
        bit          ev;
        logic [19:0] ed;
        bit          erd;
        logic [1:0]  ek;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [1:0]  rk;
        logic [15:0] rdat;
        t6  = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                6'b011110, 6'b101011};
        t4d = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
        t4k = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
        kset = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                 8'hF7, 8'hFB, 8'hFD, 8'hFE};

        //            v  k      data      idle ld ldv  ev  exp data  erd ek
        tbl[0] = '{1, 2'b11, 16'hBCBC, 0, 0, 0,  1, 20'hA0D7C, 0, 2'b00};
        tbl[1] = '{1, 2'b00, 16'hB5B5, 0, 0, 0,  1, 20'h55555, 0, 2'b00};
        tbl[2] = '{1, 2'b00, 16'h0000, 0, 0, 0,  1, 20'h2E4B9, 0, 2'b00};
        tbl[3] = '{1, 2'b00, 16'h0000, 0, 1, 1,  1, 20'hD1B46, 1, 2'b00};
        tbl[4] = '{1, 2'b01, 16'h0000, 0, 0, 0,  1, 20'hD1B46, 1, 2'b01};
        tbl[5] = '{1, 2'b01, 16'h0000, 0, 1, 0,  1, 20'h2E4B9, 0, 2'b01};

        // Reset state
        rst_n = 1'b0;
        drive(0, 2'b00, 16'h0000, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_const("reset", 0, 20'h0, 0, 2'b00);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int n = 0; n < 6; n++) begin
            drive(tbl[n].v, tbl[n].k, tbl[n].d, tbl[n].idle, tbl[n].ld, tbl[n].ldv);
            step();
            check_const($sformatf("vec%0d", n), tbl[n].ev, tbl[n].ed, tbl[n].erd, tbl[n].ek);
            check_model($sformatf("vec%0d_model", n));
        end

        // Electrical idle: leave RD+ first, then idle 3 cycles, then K28.5 pair
        drive(1, 2'b01, 16'h00BC, 0, 0, 0);
        step();
        check_const("pre_idle", 1, 20'hD197C, 1, 2'b00);
        for (int n = 0; n < 3; n++) begin
            drive(1, 2'b01, 16'h0000, 1, 0, 0);
            step();
            check_const($sformatf("idle%0d", n), 1, 20'h0, 1, 2'b00);
        end
        drive(1, 2'b11, 16'hBCBC, 0, 0, 0);
        step();
        check_const("post_idle", 1, 20'h5F283, 1, 2'b00);

        // rd_load on an invalid cycle must not move RD
        drive(0, 2'b11, 16'hBCBC, 0, 1, 0);
        step();
        check_const("inv_load", 0, 20'h5F283, 1, 2'b00);
        drive(1, 2'b11, 16'hBCBC, 0, 0, 0);
        step();
        check_const("after_inv_load", 1, 20'h5F283, 1, 2'b00);

        // Two invalid cycles hold outputs, then an async reset between edges
        for (int n = 0; n < 2; n++) begin
            drive(0, 2'b00, 16'h1234, 0, 0, 0);
            step();
            check_const($sformatf("hold%0d", n), 0, 20'h5F283, 1, 2'b00);
        end
        drive(1, 2'b11, 16'hBCBC, 0, 0, 0);
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_const("mid_reset", 0, 20'h0, 0, 2'b00);
        #1 rst_n = 1'b1;
        step();
        check_const("post_reset", 1, 20'hA0D7C, 0, 2'b00);

        // Idle with a preload: RD register moves, out_rd does not
        drive(1, 2'b00, 16'h0000, 1, 1, 1);
        step();
        check_const("idle_load", 1, 20'h0, 0, 2'b00);
        drive(1, 2'b11, 16'hBCBC, 0, 0, 0);
        step();
        check_const("after_idle_load", 1, 20'h5F283, 1, 2'b00);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < BYTES; i++) begin
                rk[i] = ($urandom_range(0, 9) < 3);
                if (rk[i] && $urandom_range(0, 1) == 1)
                    rdat[8*i +: 8] = kset[$urandom_range(0, 11)];
                else
                    rdat[8*i +: 8] = 8'($urandom);
            end
            drive($urandom_range(0, 9) < 8, rk, rdat, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 19) < 3, 1'($urandom));
            step();
            check_model("rand");
            if (out_valid && !in_elec_idle && in_valid) begin
                for (int i = 0; i < BYTES; i++)
                    check("rand_balance", 32'($countones(out_data[10*i +: 10]) inside {4, 5, 6}), 32'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcie_phy_8b10b_enc_multi.md
Name: pcie_phy_8b10b_enc_multi

Overview:
Parametrised multi-symbol 8b/10b encoder for the PCIe PHY TX datapath. It encodes BYTES characters per clock and chains running disparity (RD) symbol-to-symbol within a word and across words. It adds an input valid/output valid pipeline stage, an electrical-idle mode, an RD preload and invalid-K flagging. Symbols are computed in 5b/6b + 3b/4b logic, not ROM, so latency is fixed. It sits between the TX framing/ordered-set mux and the serializer.

Parameters:
BYTES, 2, symbols encoded per clock (1..8); symbol 0 is first on the wire.
CHECK_K, 1, 1 = flag K inputs that are not one of the 12 valid K codes; 0 = err_k tied 0.

Ports:
clk  in  1  TX symbol clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_data  in  8*BYTES  characters; byte i = bits [8i+7:8i], HGFEDCBA with A at LSB
in_k  in  BYTES  per-byte D/K# (1 = control)
in_elec_idle  in  1  force all-zero output, RD frozen
rd_load  in  1  preload RD before encoding this cycle's word
rd_load_val  in  1  RD value to preload (0 = RD-, 1 = RD+)
out_valid  out  1  output word valid
out_data  out  10*BYTES  symbols; symbol i = bits [10i+9:10i] = {j,h,g,f,i,e,d,c,b,a}, a at bit 0, transmitted first
out_rd  out  1  RD after last symbol of current output word
err_k  out  BYTES  per-symbol invalid-K flag, aligned with out_data

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, err_k=0, RD register=0 (RD-), out_rd=0. Deasserting reset mid-stream drops any in-flight word; first accepted word encodes from RD-.
- Latency: 1 clock. A word sampled at edge N with in_valid=1 appears on out_data with out_valid=1 after edge N. All outputs are registered.
- Start RD: rd0 = rd_load ? rd_load_val : RD register. Symbol i encodes with rd_i. rd_{i+1} = rd_i XOR (symbol i disparity != 0). On edge with in_valid=1 and in_elec_idle=0: RD register <= rd_BYTES, and out_rd = rd_BYTES.
- Codes follow standard 8b/10b tables (IEEE 802.3 Cl.36). 6b sub-block selects on rd_i. 4b sub-block selects on RD after the 6b sub-block. Alternate D.x.A7 is used for x=17,18,20 when RD-, and x=11,13,14 when RD+.
- Symbol disparity is only 0 or ±2; neutral symbols hold RD.
- K codes: K28.0-7, K23.7, K27.7, K29.7, K30.7. Any other in_k byte sets err_k[i]=1 and is encoded as the D code of the same byte (RD chain uses that D code).
- in_valid=0: out_valid<=0. out_data, err_k and out_rd hold their last values. RD register unchanged, even if rd_load=1 (rd_load only qualifies a valid word).
- in_elec_idle=1 with in_valid=1: out_data<=0, out_valid<=1, err_k<=0. RD register and out_rd unchanged, except an asserted rd_load still updates the RD register to rd_load_val. All-zero output is never treated as a disparity event.
- in_elec_idle=1 with in_valid=0: same as in_valid=0.
- Simultaneous rd_load and valid word: preload applies to symbol 0 of that same word.

Test Plan:
- BYTES=2, after reset, in_k=2'b11, in_data=16'hBCBC -> next cycle out_data={10'h283,10'h17C} (sym0 K28.5 RD- = 0x17C, sym1 RD+ = 0x283), out_rd=0, err_k=0.
- Then in_k=0, in_data=16'hB5B5 (D21.5 neutral) -> out_data={10'h155,10'h155}, out_rd unchanged (0).
- From RD-, in_k=0, in_data=16'h0000 -> sym0 D0.0 = 0x0B9 (neutral), sym1 = 0x0B9, out_rd=0. Repeat with rd_load=1, rd_load_val=1 -> sym0 uses the RD+ table for D0.0.
- in_k=2'b01, in_data=16'h0000 (K0.0 invalid) -> err_k=2'b01, sym0 = D0.0 code for current RD, out_valid=1.
- Stream K28.5 pairs, then assert in_elec_idle for 3 cycles, then K28.5 again -> idle cycles give out_data=0 with out_valid=1. The next K28.5 uses the RD held before idle; out_rd is constant during idle.
- in_valid low for 2 cycles mid-stream, then async rst_n pulse between edges -> outputs hold while invalid; reset immediately clears out_valid, out_data and err_k; next K28.5 word encodes from RD- (0x17C first).
